// File: rtl/mc_cu.sv
// Multicycle MIPS control unit: Moore FSM that drives datapath enables and muxes for each instruction step.
// Latency: one state per clock; lw 5 cycles, sw/R-type/addi 4, beq/bne/j 3, mul 3+MUL_CYCLES, illegal 2.
// Backpressure: none; busy flags the MULEX stall, and opcode/funct are read live from the held IR.
module mc_cu #(
  parameter int MUL_CYCLES = 4,
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] ALUControl,
  output logic       busy,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_MULEX   = 4'd12
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // opcode / funct decode of the live IR fields
  logic is_lw, is_sw, is_rtype, is_beq, is_bne, is_addi, is_j;
  logic f_add, f_sub, f_slt, f_mul;

  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_rtype = (opcode == 6'b000000);
  assign is_beq   = (opcode == 6'b000100);
  assign is_bne   = ENABLE_BNE && (opcode == 6'b000101);
  assign is_addi  = (opcode == 6'b001000);
  assign is_j     = (opcode == 6'b000010);

  assign f_add = (funct == 6'b100000);
  assign f_sub = (funct == 6'b100010);
  assign f_slt = (funct == 6'b101010);
  assign f_mul = (funct == 6'b011100);

  // raw strobes before reset gating
  logic pcwrite_c, irwrite_c, memwrite_c, regwrite_c, illegal_c, branch_c;

  // state register and MULEX down-counter; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state selection and Moore outputs for the current state
  always_comb begin
    state_d    = S_FETCH;
    cnt_d      = cnt_q;
    pcwrite_c  = 1'b0;
    irwrite_c  = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    illegal_c  = 1'b0;
    branch_c   = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    ALUControl = 3'b000;
    busy       = 1'b0;

    case (state_q)
      S_FETCH: begin
        irwrite_c  = 1'b1;
        pcwrite_c  = 1'b1;
        alusrcb    = 2'b01;
        ALUControl = 3'b010;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        alusrcb    = 2'b11;
        ALUControl = 3'b010;
        if (is_lw || is_sw) begin
          state_d = S_MEMADR;
        end else if (is_rtype) begin
          if (f_mul) begin
            state_d = S_MULEX;
            cnt_d   = CW'(MUL_CYCLES - 1);
          end else if (f_add || f_sub || f_slt) begin
            state_d = S_EXECUTE;
          end else begin
            illegal_c = 1'b1;
          end
        end else if (is_beq || is_bne) begin
          state_d = S_BRANCH;
        end else if (is_addi) begin
          state_d = S_ADDIEX;
        end else if (is_j) begin
          state_d = S_JUMP;
        end else begin
          illegal_c = 1'b1;
        end
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        ALUControl = 3'b010;
        state_d    = (state_q == S_ADDIEX) ? S_ADDIWB : (is_sw ? S_MEMWR : S_MEMRD);
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        if (f_sub)      ALUControl = 3'b100;
        else if (f_slt) ALUControl = 3'b110;
        else            ALUControl = 3'b010;
        state_d = S_ALUWB;
      end
      S_MULEX: begin
        alusrca    = 1'b1;
        ALUControl = 3'b101;
        busy       = 1'b1;
        // counter holds at zero on exit so it never wraps
        if (cnt_q == '0) begin
          state_d = S_ALUWB;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          state_d = S_MULEX;
        end
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        ALUControl = 3'b100;
        pcsrc      = 2'b01;
        branch_c   = (is_beq && zero) || (is_bne && !zero);
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        pcwrite_c = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // write strobes are held off for the whole reset interval
  assign pcen     = rst_n & (pcwrite_c | branch_c);
  assign irwrite  = rst_n & irwrite_c;
  assign memwrite = rst_n & memwrite_c;
  assign regwrite = rst_n & regwrite_c;
  assign illegal  = rst_n & illegal_c;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_cu.sv
// Bench for mc_cu: two instances (MUL_CYCLES=4/bne on, MUL_CYCLES=1/bne off) share clock, reset and IR inputs.
// Expected per-cycle state and control words are queued when an instruction is issued and checked on negedges.
// Only the instance selected by sel is compared; reset pulses resynchronise both instances.
module tb_mc_cu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero;
  bit         sel;

  // control word: pcen iord memwrite irwrite regdst memtoreg regwrite alusrca alusrcb[2] pcsrc[2] alu[3] busy illegal
  wire [16:0] c0, c1;
  wire [3:0]  s0, s1;

  always #5 clk = ~clk;

  mc_cu #(.MUL_CYCLES(4), .ENABLE_BNE(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pcen(c0[16]), .iord(c0[15]), .memwrite(c0[14]), .irwrite(c0[13]), .regdst(c0[12]),
    .memtoreg(c0[11]), .regwrite(c0[10]), .alusrca(c0[9]), .alusrcb(c0[8:7]), .pcsrc(c0[6:5]),
    .ALUControl(c0[4:2]), .busy(c0[1]), .illegal(c0[0]), .state(s0)
  );

  mc_cu #(.MUL_CYCLES(1), .ENABLE_BNE(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pcen(c1[16]), .iord(c1[15]), .memwrite(c1[14]), .irwrite(c1[13]), .regdst(c1[12]),
    .memtoreg(c1[11]), .regwrite(c1[10]), .alusrca(c1[9]), .alusrcb(c1[8:7]), .pcsrc(c1[6:5]),
    .ALUControl(c1[4:2]), .busy(c1[1]), .illegal(c1[0]), .state(s1)
  );

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [16:0] RESET_CTL = 17'b0_0_0_0_0_0_0_0_01_00_010_0_0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit legal(input logic [5:0] opc, input logic [5:0] fn, input bit enb);
    case (opc)
      6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
      6'b000101: return enb;
      6'b000000: return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b101010) || (fn == 6'b011100);
      default:   return 1'b0;
    endcase
  endfunction

  // expected control word for one cycle, written straight from the state output table
  function automatic logic [16:0] ctrl_of(input int st, input logic [5:0] opc, input logic [5:0] fn,
                                          input logic z, input bit enb);
    logic pc, io, mw, ir, rd, mr, rw, sa, bu, il;
    logic [1:0] sb, ps;
    logic [2:0] al;
    {pc, io, mw, ir, rd, mr, rw, sa, bu, il} = '0;
    sb = 2'b00; ps = 2'b00; al = 3'b000;
    case (st)
      0:  begin ir = 1; pc = 1; sb = 2'b01; al = 3'b010; end
      1:  begin sb = 2'b11; al = 3'b010; il = !legal(opc, fn, enb); end
      2, 9: begin sa = 1; sb = 2'b10; al = 3'b010; end
      3:  io = 1;
      5:  begin io = 1; mw = 1; end
      4:  begin mr = 1; rw = 1; end
      10: rw = 1;
      7:  begin rd = 1; rw = 1; end
      6:  begin
            sa = 1;
            al = (fn == 6'b100010) ? 3'b100 : (fn == 6'b101010) ? 3'b110 : 3'b010;
          end
      12: begin sa = 1; al = 3'b101; bu = 1; end
      8:  begin
            sa = 1; al = 3'b100; ps = 2'b01;
            pc = ((opc == 6'b000100) && z) || (enb && (opc == 6'b000101) && !z);
          end
      11: begin ps = 2'b10; pc = 1; end
      default: ;
    endcase
    return {pc, io, mw, ir, rd, mr, rw, sa, sb, ps, al, bu, il};
  endfunction

  // issue one instruction at the start of a FETCH cycle (posedge+1); lim>0 truncates the run
  task automatic run(input bit s, input logic [5:0] opc, input logic [5:0] fn, input logic z,
                     input string tag, input int lim);
    int sts[$];
    int m;
    bit enb;
    m   = s ? 1 : 4;
    enb = !s;
    sts.push_back(0);
    sts.push_back(1);
    if (legal(opc, fn, enb)) begin
      case (opc)
        6'b100011: begin sts.push_back(2); sts.push_back(3); sts.push_back(4); end
        6'b101011: begin sts.push_back(2); sts.push_back(5); end
        6'b000000: begin
          if (fn == 6'b011100) for (int k = 0; k < m; k++) sts.push_back(12);
          else sts.push_back(6);
          sts.push_back(7);
        end
        6'b000100, 6'b000101: sts.push_back(8);
        6'b001000: begin sts.push_back(9); sts.push_back(10); end
        6'b000010: sts.push_back(11);
        default: ;
      endcase
    end
    while (lim > 0 && sts.size() > lim) void'(sts.pop_back());
    sel = s; opcode = opc; funct = fn; zero = z;
    foreach (sts[i]) begin
      exp_t e;
      e.st  = 4'(sts[i]);
      e.ctl = ctrl_of(sts[i], opc, fn, z, enb);
      e.tag = $sformatf("%s c%0d", tag, i);
      sbq.push_back(e);
    end
    repeat (sts.size()) @(posedge clk);
    #1;
  endtask

  // scoreboard consumer: one expected cycle per negedge
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk({mon_e.tag, " state"}, sel ? s1 : s0, mon_e.st);
      chk({mon_e.tag, " ctl"}, sel ? c1 : c0, mon_e.ctl);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; sel = 1'b0;
    #1;
    chk("rst state", s0, 4'd0);
    chk("rst ctl", c0, RESET_CTL);
    @(posedge clk); #1;
    chk("rst held state", s0, 4'd0);
    chk("rst held ctl1", c1, RESET_CTL);
    rst_n = 1'b1;

    run(0, 6'b100011, 6'b000000, 1'b0, "lw", 0);
    run(0, 6'b101011, 6'b000000, 1'b0, "sw", 0);
    run(0, 6'b000000, 6'b100000, 1'b0, "add", 0);
    run(0, 6'b000000, 6'b100010, 1'b0, "sub", 0);
    run(0, 6'b000000, 6'b101010, 1'b0, "slt", 0);
    run(0, 6'b000000, 6'b011100, 1'b0, "mul4", 0);
    run(0, 6'b000100, 6'b000000, 1'b1, "beq z1", 0);
    run(0, 6'b000100, 6'b000000, 1'b0, "beq z0", 0);
    run(0, 6'b000101, 6'b000000, 1'b1, "bne z1", 0);
    run(0, 6'b000101, 6'b000000, 1'b0, "bne z0", 0);
    run(0, 6'b001000, 6'b000000, 1'b0, "addi", 0);
    run(0, 6'b000010, 6'b000000, 1'b0, "j", 0);
    run(0, 6'b111111, 6'b000000, 1'b0, "ill op", 0);
    run(0, 6'b000000, 6'b000111, 1'b0, "ill fn", 0);
    run(0, 6'b100011, 6'b000000, 1'b0, "lw2", 0);

    // abort a mul during its second MULEX cycle
    run(0, 6'b000000, 6'b011100, 1'b0, "mulabort", 3);
    chk("mulex2 state", s0, 4'd12);
    chk("mulex2 busy", c0[1], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async rst state", s0, 4'd0);
    chk("async rst ctl", c0, RESET_CTL);
    @(posedge clk); #1;
    chk("rst hold state", s0, 4'd0);
    chk("rst hold cnt-free ctl", c0, RESET_CTL);
    rst_n = 1'b1;
    run(0, 6'b000000, 6'b011100, 1'b0, "mul after rst", 0);
    run(0, 6'b101011, 6'b000000, 1'b0, "sw2", 0);

    // resynchronise both instances, then exercise MUL_CYCLES=1 / ENABLE_BNE=0
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(1, 6'b000000, 6'b011100, 1'b0, "mul1", 0);
    run(1, 6'b000101, 6'b000000, 1'b0, "nobne z0", 0);
    run(1, 6'b000101, 6'b000000, 1'b1, "nobne z1", 0);
    run(1, 6'b000100, 6'b000000, 1'b1, "beq1 z1", 0);
    run(1, 6'b000000, 6'b100000, 1'b0, "add1", 0);

    @(negedge clk);
    chk("sb empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
